// File: rtl/types_pkg.sv
// Shared core types plus the ID/EX pipeline-register additions.
// Build option: define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
package types_pkg;

    localparam int XLEN_P = 64;
    localparam int RIDX_P = 5;

    typedef logic [XLEN_P-1:0] dword_t;
    typedef logic [RIDX_P-1:0] regbits_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        dword_t   rs1_data;
        dword_t   rs2_data;
        dword_t   imm;
        dword_t   pc;
        regbits_t rs1;
        regbits_t rs2;
        regbits_t rd;
        aluop_t   aluop;
        logic     use_pc;
        logic     use_imm;
        logic     reg_write;
    } id_ex_t;

    // Picks the operand value named by a forward select.
    function automatic dword_t fwd_mux(fwd_sel_t sel, dword_t reg_v, dword_t exmem_v, dword_t memwb_v);
        dword_t r;
        case (sel)
            FWD_EXMEM: r = exmem_v;
            FWD_MEMWB: r = memwb_v;
            default:   r = reg_v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Forward-source selection for one operand index; EX/MEM beats MEM/WB and x0 never forwards.
module forward_unit
    import types_pkg::*;
(
    input  regbits_t src_idx_i,
    input  logic     exmem_reg_write_i,
    input  regbits_t exmem_rd_i,
    input  logic     memwb_reg_write_i,
    input  regbits_t memwb_rd_i,
    output fwd_sel_t sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (src_idx_i != '0) begin
            if (exmem_reg_write_i && (exmem_rd_i == src_idx_i)) begin
                sel_o = FWD_EXMEM;
            end else if (memwb_reg_write_i && (memwb_rd_i == src_idx_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with flush and combinational operand forwarding.
// Build option: ID_EX_FORWARDING_EN enables the forward_unit instances; otherwise operands come from the register file.
module id_ex_stage
    import types_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RIDX = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RIDX-1:0] in_rs1,
    input  logic [RIDX-1:0] in_rs2,
    input  logic [RIDX-1:0] in_rd,
    input  aluop_t          in_aluop,
    input  logic            in_use_pc,
    input  logic            in_use_imm,
    input  logic            in_reg_write,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [RIDX-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RIDX-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] porta,
    output logic [XLEN-1:0] portb,
    output aluop_t          ALUOp,
    output logic [RIDX-1:0] out_rd,
    output logic            out_reg_write,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_store_data
);

    // Handshake: a transfer happens on a rising edge where valid && ready on the same side;
    // valid never depends on ready, and a stalled stage holds every field until out_ready rises.
    id_ex_t   ex_q, ex_d;
    logic     valid_q, valid_d;
    logic     capture;
    fwd_sel_t sel_rs1, sel_rs2;
    dword_t   rs1_val, rs2_val;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready;

    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d          = 1'b1;
            ex_d.rs1_data    = in_rs1_data;
            ex_d.rs2_data    = in_rs2_data;
            ex_d.imm         = in_imm;
            ex_d.pc          = in_pc;
            ex_d.rs1         = in_rs1;
            ex_d.rs2         = in_rs2;
            ex_d.rd          = in_rd;
            ex_d.aluop       = in_aluop;
            ex_d.use_pc      = in_use_pc;
            ex_d.use_imm     = in_use_imm;
            ex_d.reg_write   = in_reg_write;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    forward_unit u_fwd_rs1 (
        .src_idx_i         (ex_q.rs1),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .sel_o             (sel_rs1)
    );

    forward_unit u_fwd_rs2 (
        .src_idx_i         (ex_q.rs2),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .sel_o             (sel_rs2)
    );
`else
    // Decode stalls on hazards in this build, so the forward sources are never consulted.
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
                          exmem_result, memwb_result, ex_q.rs1, ex_q.rs2};
    assign sel_rs1 = FWD_NONE;
    assign sel_rs2 = FWD_NONE;
`endif

    assign rs1_val = fwd_mux(sel_rs1, ex_q.rs1_data, exmem_result, memwb_result);
    assign rs2_val = fwd_mux(sel_rs2, ex_q.rs2_data, exmem_result, memwb_result);

    assign porta          = ex_q.use_pc  ? ex_q.pc  : rs1_val;
    assign portb          = ex_q.use_imm ? ex_q.imm : rs2_val;
    assign out_store_data = rs2_val;
    assign out_valid      = valid_q;
    assign ALUOp          = ex_q.aluop;
    assign out_rd         = ex_q.rd;
    assign out_reg_write  = ex_q.reg_write;
    assign out_pc         = ex_q.pc;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RV64 core, directly upstream of the ALU. Registers one decoded instruction's operands and controls under a valid/ready handshake, with stall and flush support. On the output side it selects the ALU's `porta`/`portb`/`ALUOp`, resolving RAW hazards by forwarding from the EX/MEM and MEM/WB results.

## Interface
Parameters
- `XLEN`, 64: operand width; must equal `dword_t` width.
- `RIDX`, 5: register index width.

Ports
- `CLK`  in  1  core clock.
- `RST`  in  1  reset, asynchronous and active-high; this polarity and synchronicity are fixed.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register file read data.
- `in_imm`, `in_pc`  in  XLEN  sign-extended immediate; instruction PC.
- `in_rs1`, `in_rs2`, `in_rd`  in  RIDX  source/destination indices.
- `in_aluop`  in  aluop_t  ALU operation.
- `in_use_pc`  in  1  porta takes PC instead of rs1.
- `in_use_imm`  in  1  portb takes imm instead of rs2.
- `in_reg_write`  in  1  instruction writes rd.
- `flush`  in  1  kill the held instruction (branch redirect).
- `exmem_reg_write`, `exmem_rd`, `exmem_result`  in  1/RIDX/XLEN  EX/MEM forward source.
- `memwb_reg_write`, `memwb_rd`, `memwb_result`  in  1/RIDX/XLEN  MEM/WB forward source.
- `out_valid`  out  1  execute holds a live instruction.
- `out_ready`  in  1  execute consumes this cycle.
- `porta`, `portb`  out  XLEN  ALU operands.
- `ALUOp`  out  aluop_t  registered ALU op.
- `out_rd`, `out_reg_write`, `out_pc`  out  RIDX/1/XLEN  passed down the pipe.
- `out_store_data`  out  XLEN  forwarded rs2 value, never the immediate.

## Operation
- One-entry register. `in_ready = !out_valid || out_ready` (combinational).
- Capture when `in_valid && in_ready`: all `in_*` fields load and `out_valid` goes to 1.
- `out_valid && out_ready` with no capture sets `out_valid` to 0. Fields hold their values; they are don't-care while invalid.
- `out_valid && !out_ready` is a stall: every registered field holds and `in_ready` = 0.
- `flush` has top priority. Next cycle `out_valid` = 0, and any simultaneous capture is dropped. `in_ready` is not gated by `flush`.
- Operand resolution is combinational from the registered fields plus the live forward inputs:
  - rs1 value = EX/MEM if `exmem_reg_write && exmem_rd == rs1 && rs1 != 0`;
  - otherwise MEM/WB under the same test;
  - otherwise the registered `rs1_data`.
  - rs2 is resolved the same way.
  - EX/MEM always wins over MEM/WB. Index 0 is never forwarded.
- `porta` = `use_pc` ? `pc` : resolved rs1.
- `portb` = `use_imm` ? `imm` : resolved rs2.
- `out_store_data` = resolved rs2.
- Reset value of all outputs and registered state is 0, `out_valid` = 0. `in_ready` therefore reads 1 during and after reset.
- Reset asserted mid-stall drops the held instruction immediately (asynchronous).

## Timing
- Latency is 1 cycle: accepted on edge N, `out_valid` = 1 from edge N onward.
- Throughput is 1 instruction/cycle when `out_ready` is held high.
- Forward-to-port is a purely combinational path. The ALU sees the updated operand in the same cycle a forward source changes.
- Flush takes effect at the next edge; `out_valid` stays high for the remainder of the flush cycle.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding as described.
- `ID_EX_FORWARDING_EN` undefined:
  - resolved rs1/rs2 are the registered register-file data;
  - all `exmem_*`/`memwb_*` inputs are ignored;
  - hazard handling is left to decode stalls.
- Handshake behaviour is identical in both builds.

## Structure
- `types_pkg` additions:
  - `regbits_t` (RIDX-bit index);
  - `fwd_sel_t` enum {FWD_NONE, FWD_EXMEM, FWD_MEMWB};
  - a packed `id_ex_t` struct of the registered fields.
- Reuse the existing `dword_t` and `aluop_t`.
- One sub-module, `forward_unit`: takes one source index plus both forward sources and returns a `fwd_sel_t`. It is instantiated twice (rs1, rs2) and only under `ID_EX_FORWARDING_EN`.
- Optionally add `id_ex_if` with `stage`/`tb` modports.

## Test plan
- Reset, then capture rs1_data=5, rs2_data=7, use_imm=0: `out_valid`=1 next cycle, porta=5, portb=7, ALUOp matches.
- Held rs1=3 with exmem_reg_write=1, exmem_rd=3, exmem_result=0xAA, and memwb_rd=3, memwb_result=0xBB: porta=0xAA. Drop exmem_reg_write: porta=0xBB.
- rs1=0, exmem_rd=0, exmem_result=0xFF, rs1_data=0: porta=0 (no x0 forward).
- out_ready=0 for 3 cycles with in_valid=1: `in_ready`=0 and fields unchanged. out_ready=1: next instruction captured the following edge.
- flush together with in_valid=1, in_ready=1: `out_valid`=0 next cycle and the new instruction is discarded.
- use_pc=1, pc=0x1000, use_imm=1, imm=-4, rs2 forwarded to 0x55: porta=0x1000, portb=0xFFFF_FFFF_FFFF_FFFC, out_store_data=0x55.
